// File: rtl/proc_selfcheck_sequencer.sv
// -----------------------------------------------------------------------------
// proc_selfcheck_sequencer
//
// On-chip self-check for a processor core. One run:
//   1. hold the processor in reset (clock enabled) for RESET_CYCLES cycles,
//   2. let it execute for a cycle budget latched from run_cycles,
//   3. freeze it (clock enable low, reset low) and walk the GPR debug read
//      port from r1 to r(NUM_REGS-1), comparing each word with the
//      expected-value ROM addressed by the same index,
//   4. report pass/fail, first failing register, mismatch count and the
//      number of processor cycles executed.
//
// Ports
//   clk, reset         system clock (rising edge), synchronous active-high reset
//   start              one-cycle request, honoured only in IDLE or DONE
//   run_cycles         processor cycle budget, latched when start is accepted
//   proc_reset         reset to the processor
//   proc_clk_en        processor clock enable
//   reg_rd_addr        GPR debug read index, also the expected-ROM index
//   reg_rd_data        asynchronous GPR read data for reg_rd_addr
//   exp_rd_data        asynchronous expected-ROM data for reg_rd_addr
//   busy / done        run in progress / results valid
//   pass               done and no mismatches
//   fail_index         first mismatching register (0 if none)
//   fail_actual        GPR value at fail_index
//   fail_expected      expected value at fail_index
//   mismatch_cnt       number of mismatching registers
//   cycle_cnt          processor cycles executed in the last run
// -----------------------------------------------------------------------------
module proc_selfcheck_sequencer #(
  parameter int DATA_WIDTH   = 32,
  parameter int NUM_REGS     = 32,
  parameter int ADDR_WIDTH   = 5,
  parameter int CYC_WIDTH    = 16,
  parameter int RESET_CYCLES = 2,
  parameter bit STOP_ON_FAIL = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [CYC_WIDTH-1:0]  run_cycles,
  output logic                  proc_reset,
  output logic                  proc_clk_en,
  output logic [ADDR_WIDTH-1:0] reg_rd_addr,
  input  logic [DATA_WIDTH-1:0] reg_rd_data,
  input  logic [DATA_WIDTH-1:0] exp_rd_data,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [ADDR_WIDTH-1:0] fail_index,
  output logic [DATA_WIDTH-1:0] fail_actual,
  output logic [DATA_WIDTH-1:0] fail_expected,
  output logic [ADDR_WIDTH:0]   mismatch_cnt,
  output logic [CYC_WIDTH-1:0]  cycle_cnt
);

  // Reset-phase counter runs 0..RESET_CYCLES-1.
  localparam int RST_W = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
  localparam logic [RST_W-1:0]      RST_LAST  = RST_W'(RESET_CYCLES - 1);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(NUM_REGS - 1);
  localparam logic [ADDR_WIDTH-1:0] FIRST_REG = ADDR_WIDTH'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RESET_DUT,
    S_RUN,
    S_CHECK,
    S_DONE
  } state_t;

  state_t               state, state_nxt;
  logic [CYC_WIDTH-1:0] budget;
  logic [RST_W-1:0]     rst_cnt;

  logic rst_last;
  logic run_last;
  logic cmp_eq;
  logic cmp_mismatch;
  logic check_last;
  logic start_ok;

  // ---------------------------------------------------------------------------
  // Phase-end and compare decode
  // ---------------------------------------------------------------------------
  always_comb begin
    rst_last = (rst_cnt == RST_LAST);
    // Extended by one bit so a budget of all-ones ends cleanly without the
    // cycle counter ever wrapping.
    run_last = (({1'b0, cycle_cnt} + (CYC_WIDTH+1)'(1)) == {1'b0, budget});
    cmp_eq   = (reg_rd_data == exp_rd_data);
    // An unknown compare result (X on read data in simulation) is a mismatch.
    cmp_mismatch = (cmp_eq !== 1'b1);
    check_last   = (reg_rd_addr == LAST_ADDR) || (STOP_ON_FAIL && cmp_mismatch);
    start_ok     = start && ((state == S_IDLE) || (state == S_DONE));
  end

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  // NOTE: reset is synchronous here, so it is tested inside the clocked
  // branch rather than listed in the sensitivity list.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: state_nxt gets a default before the case so every path assigns it;
  // a missing assignment in combinational logic would infer a latch.
  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE, S_DONE: begin
        if (start_ok) state_nxt = S_RESET_DUT;
      end
      S_RESET_DUT: begin
        if (rst_last) state_nxt = (budget != '0) ? S_RUN : S_CHECK;
      end
      S_RUN: begin
        if (run_last) state_nxt = S_CHECK;
      end
      S_CHECK: begin
        if (check_last) state_nxt = S_DONE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Moore outputs decoded from the state register
  // ---------------------------------------------------------------------------
  always_comb begin
    proc_reset  = 1'b0;
    proc_clk_en = 1'b0;
    busy        = 1'b0;
    done        = 1'b0;
    unique case (state)
      S_IDLE:      proc_reset = 1'b1;
      S_RESET_DUT: begin
        proc_reset  = 1'b1;
        proc_clk_en = 1'b1;
        busy        = 1'b1;
      end
      S_RUN: begin
        proc_clk_en = 1'b1;
        busy        = 1'b1;
      end
      S_CHECK:     busy = 1'b1;
      S_DONE:      done = 1'b1;
      default:     proc_reset = 1'b1;
    endcase
    pass = done && (mismatch_cnt == '0);
  end

  // ---------------------------------------------------------------------------
  // Counters, read index and result capture
  // ---------------------------------------------------------------------------
  // NOTE: all sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      budget        <= '0;
      rst_cnt       <= '0;
      cycle_cnt     <= '0;
      reg_rd_addr   <= '0;
      mismatch_cnt  <= '0;
      fail_index    <= '0;
      fail_actual   <= '0;
      fail_expected <= '0;
    end else begin
      unique case (state)
        S_IDLE, S_DONE: begin
          if (start_ok) begin
            budget        <= run_cycles;
            rst_cnt       <= '0;
            cycle_cnt     <= '0;
            reg_rd_addr   <= '0;
            mismatch_cnt  <= '0;
            fail_index    <= '0;
            fail_actual   <= '0;
            fail_expected <= '0;
          end
        end
        S_RESET_DUT: begin
          rst_cnt <= rst_cnt + RST_W'(1);
          // Point at r1 now so the scan is ready whichever way we leave.
          if (rst_last) reg_rd_addr <= FIRST_REG;
        end
        S_RUN: begin
          cycle_cnt <= cycle_cnt + CYC_WIDTH'(1);
        end
        S_CHECK: begin
          if (cmp_mismatch) begin
            mismatch_cnt <= mismatch_cnt + (ADDR_WIDTH+1)'(1);
            if (mismatch_cnt == '0) begin
              fail_index    <= reg_rd_addr;
              fail_actual   <= reg_rd_data;
              fail_expected <= exp_rd_data;
            end
          end
          // The index stays on the last compared register once DONE is reached.
          if (!check_last) reg_rd_addr <= reg_rd_addr + ADDR_WIDTH'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_proc_selfcheck_sequencer.sv
// -----------------------------------------------------------------------------
// tb_proc_selfcheck_sequencer
//
// Two sequencers share clock, reset, start and run_cycles: u_stop stops at the
// first mismatch, u_scan scans every register. Each drives its own behavioural
// "processor" that writes Fibonacci numbers into r1, r2, ... one register per
// enabled, non-reset cycle; reset preloads r1..r31 with 0xcafebabe. Expected
// results are pushed per instance when start is driven and popped when done
// rises.
// -----------------------------------------------------------------------------
module tb_proc_selfcheck_sequencer;

  localparam int NR = 32;
  localparam int RC = 2;
  localparam logic [31:0] PRELOAD = 32'hcafebabe;

  typedef struct {
    logic        pass;
    logic [4:0]  fidx;
    logic [31:0] fact;
    logic [31:0] fexp;
    logic [5:0]  mcnt;
    logic [15:0] ccnt;
    int          lat;
    int          en_exp;
    int          start_cyc;
    int          en_base;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [15:0] run_cycles;

  logic [1:0]  proc_reset_v, proc_clk_en_v, busy_v, done_v, pass_v;
  logic [4:0]  rd_addr_v   [2];
  logic [31:0] rd_data_v   [2];
  logic [31:0] exp_data_v  [2];
  logic [4:0]  fail_idx_v  [2];
  logic [31:0] fail_act_v  [2];
  logic [31:0] fail_exp_v  [2];
  logic [5:0]  mcnt_v      [2];
  logic [15:0] ccnt_v      [2];

  logic [31:0] gpr     [2][NR];
  int          pc      [2];
  logic [31:0] exp_rom [NR];

  int   cyc = 0;
  int   en_total [2] = '{0, 0};
  logic [1:0] done_q = 2'b00;

  exp_t sb0 [$];
  exp_t sb1 [$];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  proc_selfcheck_sequencer #(.STOP_ON_FAIL(1'b1)) u_stop (
    .clk(clk), .reset(reset), .start(start), .run_cycles(run_cycles),
    .proc_reset(proc_reset_v[0]), .proc_clk_en(proc_clk_en_v[0]),
    .reg_rd_addr(rd_addr_v[0]), .reg_rd_data(rd_data_v[0]),
    .exp_rd_data(exp_data_v[0]), .busy(busy_v[0]), .done(done_v[0]),
    .pass(pass_v[0]), .fail_index(fail_idx_v[0]), .fail_actual(fail_act_v[0]),
    .fail_expected(fail_exp_v[0]), .mismatch_cnt(mcnt_v[0]),
    .cycle_cnt(ccnt_v[0])
  );

  proc_selfcheck_sequencer #(.STOP_ON_FAIL(1'b0)) u_scan (
    .clk(clk), .reset(reset), .start(start), .run_cycles(run_cycles),
    .proc_reset(proc_reset_v[1]), .proc_clk_en(proc_clk_en_v[1]),
    .reg_rd_addr(rd_addr_v[1]), .reg_rd_data(rd_data_v[1]),
    .exp_rd_data(exp_data_v[1]), .busy(busy_v[1]), .done(done_v[1]),
    .pass(pass_v[1]), .fail_index(fail_idx_v[1]), .fail_actual(fail_act_v[1]),
    .fail_expected(fail_exp_v[1]), .mismatch_cnt(mcnt_v[1]),
    .cycle_cnt(ccnt_v[1])
  );

  assign rd_data_v[0]  = gpr[0][rd_addr_v[0]];
  assign rd_data_v[1]  = gpr[1][rd_addr_v[1]];
  assign exp_data_v[0] = exp_rom[rd_addr_v[0]];
  assign exp_data_v[1] = exp_rom[rd_addr_v[1]];

  function automatic logic [31:0] fib(int n);
    logic [31:0] a = 32'd0;
    logic [31:0] b = 32'd1;
    logic [31:0] t;
    for (int k = 1; k < n; k++) begin
      t = a + b;
      a = b;
      b = t;
    end
    return b;
  endfunction

  // Register r after a run of budget b on the behavioural processor.
  function automatic logic [31:0] model_val(int r, int b);
    if (r == 0) return 32'd0;
    return (r <= b) ? fib(r) : PRELOAD;
  endfunction

  // Behavioural processor and free-running bookkeeping.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    for (int i = 0; i < 2; i++) begin
      if (proc_clk_en_v[i]) begin
        en_total[i] <= en_total[i] + 1;
        if (proc_reset_v[i]) begin
          pc[i] <= 0;
          for (int r = 0; r < NR; r++) gpr[i][r] <= (r == 0) ? 32'd0 : PRELOAD;
        end else begin
          if (pc[i] < NR - 1) gpr[i][pc[i] + 1] <= fib(pc[i] + 1);
          pc[i] <= pc[i] + 1;
        end
      end
    end
  end

  task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Build the expected outcome of a run with budget b for both instances.
  task automatic push_expect(int b);
    for (int i = 0; i < 2; i++) begin
      exp_t e;
      int   first;
      logic [31:0] act;
      e = '{default: '0};
      first = 0;
      for (int r = 1; r < NR; r++) begin
        act = model_val(r, b);
        if (exp_rom[r] !== act) begin
          e.mcnt = e.mcnt + 6'd1;
          if (e.mcnt == 6'd1) begin
            first  = r;
            e.fidx = 5'(r);
            e.fact = act;
            e.fexp = exp_rom[r];
          end
          if (i == 0) break;
        end
      end
      e.pass      = (e.mcnt == 6'd0);
      e.ccnt      = 16'(b);
      e.lat       = RC + b + ((i == 0 && e.mcnt != 6'd0) ? first : NR - 1);
      e.en_exp    = RC + b;
      e.start_cyc = cyc + 1;
      e.en_base   = en_total[i];
      if (i == 0) sb0.push_back(e);
      else        sb1.push_back(e);
    end
  endtask

  task automatic handle_done(int i);
    exp_t e;
    bit   have;
    have = 1'b0;
    if (i == 0 && sb0.size() > 0) begin
      e = sb0.pop_front();
      have = 1'b1;
    end else if (i == 1 && sb1.size() > 0) begin
      e = sb1.pop_front();
      have = 1'b1;
    end
    check($sformatf("u%0d_done_expected", i), 64'(have), 64'd1);
    if (have) begin
      check($sformatf("u%0d_pass", i),          64'(pass_v[i]),      64'(e.pass));
      check($sformatf("u%0d_fail_index", i),    64'(fail_idx_v[i]),  64'(e.fidx));
      check($sformatf("u%0d_fail_actual", i),   64'(fail_act_v[i]),  64'(e.fact));
      check($sformatf("u%0d_fail_expected", i), 64'(fail_exp_v[i]),  64'(e.fexp));
      check($sformatf("u%0d_mismatch_cnt", i),  64'(mcnt_v[i]),      64'(e.mcnt));
      check($sformatf("u%0d_cycle_cnt", i),     64'(ccnt_v[i]),      64'(e.ccnt));
      check($sformatf("u%0d_latency", i),       64'(cyc - e.start_cyc), 64'(e.lat));
      check($sformatf("u%0d_clk_en_cycles", i), 64'(en_total[i] - e.en_base),
            64'(e.en_exp));
    end
  endtask

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (done_v[i] && !done_q[i]) handle_done(i);
    end
    done_q <= done_v;
  end

  task automatic pulse_start(int b, bit expect_done);
    @(negedge clk);
    run_cycles = 16'(b);
    if (expect_done) push_expect(b);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_results(int bound);
    int n = 0;
    while ((sb0.size() != 0 || sb1.size() != 0) && n < bound) begin
      @(negedge clk);
      n++;
    end
    check("results_within_bound", 64'(sb0.size() + sb1.size()), 64'd0);
    sb0.delete();
    sb1.delete();
  endtask

  task automatic check_idle(string tag);
    for (int i = 0; i < 2; i++) begin
      check($sformatf("%s_u%0d_proc_reset", tag, i),  64'(proc_reset_v[i]),  64'd1);
      check($sformatf("%s_u%0d_proc_clk_en", tag, i), 64'(proc_clk_en_v[i]), 64'd0);
      check($sformatf("%s_u%0d_busy", tag, i),        64'(busy_v[i]),        64'd0);
      check($sformatf("%s_u%0d_done", tag, i),        64'(done_v[i]),        64'd0);
      check($sformatf("%s_u%0d_pass", tag, i),        64'(pass_v[i]),        64'd0);
      check($sformatf("%s_u%0d_rd_addr", tag, i),     64'(rd_addr_v[i]),     64'd0);
      check($sformatf("%s_u%0d_fail_index", tag, i),  64'(fail_idx_v[i]),    64'd0);
      check($sformatf("%s_u%0d_fail_actual", tag, i), 64'(fail_act_v[i]),    64'd0);
      check($sformatf("%s_u%0d_fail_exp", tag, i),    64'(fail_exp_v[i]),    64'd0);
      check($sformatf("%s_u%0d_mismatch", tag, i),    64'(mcnt_v[i]),        64'd0);
      check($sformatf("%s_u%0d_cycle_cnt", tag, i),   64'(ccnt_v[i]),        64'd0);
    end
  endtask

  task automatic load_rom(int b);
    for (int r = 0; r < NR; r++) exp_rom[r] = model_val(r, b);
  endtask

  initial begin
    reset      = 1'b1;
    start      = 1'b0;
    run_cycles = '0;
    load_rom(29);
    repeat (3) @(negedge clk);
    check_idle("reset");

    // start together with reset: reset wins
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("start_with_reset_u0_busy", 64'(busy_v[0]), 64'd0);
    check("start_with_reset_u1_busy", 64'(busy_v[1]), 64'd0);
    reset = 1'b0;
    @(negedge clk);
    check_idle("idle");

    // 1: matching expected file, B=29
    load_rom(29);
    pulse_start(29, 1'b1);
    wait_results(200);

    // 2: r7 corrupted
    load_rom(29);
    exp_rom[7] = PRELOAD;
    pulse_start(29, 1'b1);
    wait_results(200);

    // 3: r3, r9, r31 corrupted
    load_rom(29);
    exp_rom[3]  = exp_rom[3]  ^ 32'h1;
    exp_rom[9]  = exp_rom[9]  ^ 32'h1;
    exp_rom[31] = exp_rom[31] ^ 32'h1;
    pulse_start(29, 1'b1);
    wait_results(200);

    // 4: B=0, expected all preload
    for (int r = 0; r < NR; r++) exp_rom[r] = PRELOAD;
    pulse_start(0, 1'b1);
    wait_results(200);

    // 5: reset 10 cycles into RUN, then B=5
    load_rom(29);
    pulse_start(100, 1'b0);
    repeat (RC + 10) @(negedge clk);
    check("mid_run_u0_clk_en", 64'(proc_clk_en_v[0]), 64'd1);
    check("mid_run_u0_proc_reset", 64'(proc_reset_v[0]), 64'd0);
    reset = 1'b1;
    @(negedge clk);
    check_idle("abort");
    reset = 1'b0;
    load_rom(5);
    pulse_start(5, 1'b1);
    wait_results(200);

    // 6: start during CHECK ignored, start in DONE restarts
    load_rom(29);
    pulse_start(29, 1'b1);
    repeat (RC + 29 + 4) @(negedge clk);
    check("in_check_u0_busy", 64'(busy_v[0]), 64'd1);
    check("in_check_u0_clk_en", 64'(proc_clk_en_v[0]), 64'd0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_results(200);
    exp_rom[5] = PRELOAD;
    pulse_start(29, 1'b1);
    for (int i = 0; i < 2; i++) begin
      check($sformatf("restart_u%0d_done", i),       64'(done_v[i]),       64'd0);
      check($sformatf("restart_u%0d_proc_reset", i), 64'(proc_reset_v[i]), 64'd1);
      check($sformatf("restart_u%0d_busy", i),       64'(busy_v[i]),       64'd1);
    end
    wait_results(200);

    // 7: maximum budget, counter must not wrap
    load_rom(65535);
    pulse_start(65535, 1'b1);
    wait_results(66000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
